// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : instr_sequencer
// Purpose : Multi-cycle FETCH/DECODE/EXEC/WB control FSM with imem handshake.
// Revision: 1.0
// ============================================================================
module instr_sequencer #(
   parameter int PC_W     = 8,
   parameter int RESET_PC = 0,
   parameter int TIMEOUT  = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt_req,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      ir,
   input  logic             dec_reg_write,
   output logic             alu_en,
   output logic             rf_we,
   output logic [PC_W-1:0]  pc,
   output logic             busy,
   output logic             fetch_err,
   output logic [CNT_W-1:0] retired
);

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [PC_W-1:0]   c_reset_pc  = PC_W'(RESET_PC);
   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              fetch_err_q, fetch_err_d;
   logic              halt_pending_q, halt_pending_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              boundary;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         pc_q           <= c_reset_pc;
         ir_q           <= '0;
         retired_q      <= '0;
         fetch_err_q    <= 1'b0;
         halt_pending_q <= 1'b0;
         wait_q         <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         ir_q           <= ir_d;
         retired_q      <= retired_d;
         fetch_err_q    <= fetch_err_d;
         halt_pending_q <= halt_pending_d;
         wait_q         <= wait_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      ir_d           = ir_q;
      retired_d      = retired_q;
      fetch_err_d    = fetch_err_q;
      halt_pending_d = halt_pending_q;
      wait_d         = wait_q;
      boundary       = 1'b0;

      // A halt seen while busy is remembered until the next instruction boundary.
      if (state_q != S_IDLE && halt_req) begin
         halt_pending_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d        = S_FETCH;
               pc_d           = c_reset_pc;
               retired_d      = '0;
               fetch_err_d    = 1'b0;
               halt_pending_d = 1'b0;
               wait_d         = '0;
            end
         end
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + PC_W'(1);
               wait_d  = '0;
               state_d = S_DECODE;
            end else if (wait_q == c_wait_last) begin
               fetch_err_d = 1'b1;
               wait_d      = '0;
               state_d     = S_IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (dec_reg_write) begin
               state_d = S_WB;
            end else begin
               boundary = 1'b1;
            end
         end
         S_WB:     boundary = 1'b1;
         default:  state_d = S_IDLE;
      endcase

      if (boundary) begin
         if (retired_q != {CNT_W{1'b1}}) begin
            retired_d = retired_q + CNT_W'(1);
         end
         if (halt_pending_q || halt_req) begin
            state_d        = S_IDLE;
            halt_pending_d = 1'b0;
         end else begin
            state_d = S_FETCH;
            wait_d  = '0;
         end
      end
   end

   assign imem_req  = (state_q == S_FETCH);
   assign imem_addr = pc_q;
   assign ir        = ir_q;
   assign alu_en    = (state_q == S_EXEC);
   assign rf_we     = (state_q == S_WB);
   assign pc        = pc_q;
   assign busy      = (state_q != S_IDLE);
   assign fetch_err = fetch_err_q;
   assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_sequencer
// Purpose : Directed vector table plus corner sequences for instr_sequencer.
// Revision: 1.0
// ============================================================================
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        dec_reg_write = 1'b0;

   logic        imem_req, alu_en, rf_we, busy, fetch_err;
   logic [7:0]  imem_addr, pc;
   logic [31:0] ir;
   logic [15:0] retired;

   logic        s_imem_req, s_alu_en, s_rf_we, s_busy, s_fetch_err;
   logic [1:0]  s_imem_addr, s_pc, s_retired;
   logic [31:0] s_ir;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_sequencer u_dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .ir(ir), .dec_reg_write(dec_reg_write),
      .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .busy(busy),
      .fetch_err(fetch_err), .retired(retired)
   );

   instr_sequencer #(.PC_W(2), .RESET_PC(0), .TIMEOUT(15), .CNT_W(2)) u_small (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .ir(s_ir), .dec_reg_write(dec_reg_write),
      .alu_en(s_alu_en), .rf_we(s_rf_we), .pc(s_pc), .busy(s_busy),
      .fetch_err(s_fetch_err), .retired(s_retired)
   );

   typedef struct {
      logic        start, halt, ack;
      logic [31:0] rdata;
      logic        dwr;
      logic        e_req, e_alu, e_we, e_busy, e_err;
      logic [7:0]  e_pc;
      logic [15:0] e_ret;
      logic [31:0] e_ir;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [1:0] s_addrs[5];
      logic [7:0] w_addrs[5];
      int         nf;

      // start, halt, ack, rdata, dwr | req, alu, we, busy, err, pc, ret, ir
      vecs[0]  = '{1,0,0,32'h0,1'b0,          0,0,0,0,0, 8'd0, 16'd0, 32'h0};
      vecs[1]  = '{0,0,1,32'h4000_0000,1'b0,  1,0,0,1,0, 8'd0, 16'd0, 32'h0};
      vecs[2]  = '{0,0,0,32'h0,1'b1,          0,0,0,1,0, 8'd1, 16'd0, 32'h4000_0000};
      vecs[3]  = '{0,0,0,32'h0,1'b1,          0,1,0,1,0, 8'd1, 16'd0, 32'h4000_0000};
      vecs[4]  = '{0,0,0,32'h0,1'b1,          0,0,1,1,0, 8'd1, 16'd0, 32'h4000_0000};
      vecs[5]  = '{0,0,1,32'h2000_0000,1'b0,  1,0,0,1,0, 8'd1, 16'd1, 32'h4000_0000};
      vecs[6]  = '{0,0,0,32'h0,1'b0,          0,0,0,1,0, 8'd2, 16'd1, 32'h2000_0000};
      vecs[7]  = '{0,0,0,32'h0,1'b0,          0,1,0,1,0, 8'd2, 16'd1, 32'h2000_0000};
      for (int i = 8; i < 13; i++)
         vecs[i] = '{0,0,0,32'h0,1'b0,        1,0,0,1,0, 8'd2, 16'd2, 32'h2000_0000};
      vecs[13] = '{0,0,1,32'h4000_0001,1'b0,  1,0,0,1,0, 8'd2, 16'd2, 32'h2000_0000};
      vecs[14] = '{0,1,0,32'h0,1'b1,          0,0,0,1,0, 8'd3, 16'd2, 32'h4000_0001};
      vecs[15] = '{0,0,0,32'h0,1'b1,          0,1,0,1,0, 8'd3, 16'd2, 32'h4000_0001};
      vecs[16] = '{0,0,0,32'h0,1'b1,          0,0,1,1,0, 8'd3, 16'd2, 32'h4000_0001};
      vecs[17] = '{0,0,0,32'h0,1'b0,          0,0,0,0,0, 8'd3, 16'd3, 32'h4000_0001};
      vecs[18] = '{0,0,1,32'hFFFF_FFFF,1'b0,  0,0,0,0,0, 8'd3, 16'd3, 32'h4000_0001};
      vecs[19] = '{0,0,0,32'h0,1'b0,          0,0,0,0,0, 8'd3, 16'd3, 32'h4000_0001};

      // Reset held for two cycles.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.req", 32'(imem_req), 32'd0);
      chk("rst.pc", 32'(pc), 32'd0);
      chk("rst.retired", 32'(retired), 32'd0);
      chk("rst.ir", ir, 32'd0);
      chk("rst.strobes", {30'd0, alu_en, rf_we}, 32'd0);
      chk("rst.err", 32'(fetch_err), 32'd0);
      rst = 1'b0;

      // Cycle-accurate table: write instr, non-write instr, wait states, halt.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start         = vecs[i].start;
         halt_req      = vecs[i].halt;
         imem_ack      = vecs[i].ack;
         imem_rdata    = vecs[i].rdata;
         dec_reg_write = vecs[i].dwr;
         chk($sformatf("vec%0d.req", i), 32'(imem_req), 32'(vecs[i].e_req));
         if (vecs[i].e_req)
            chk($sformatf("vec%0d.addr", i), 32'(imem_addr), 32'(vecs[i].e_pc));
         chk($sformatf("vec%0d.alu_en", i), 32'(alu_en), 32'(vecs[i].e_alu));
         chk($sformatf("vec%0d.rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
         chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
         chk($sformatf("vec%0d.err", i), 32'(fetch_err), 32'(vecs[i].e_err));
         chk($sformatf("vec%0d.pc", i), 32'(pc), 32'(vecs[i].e_pc));
         chk($sformatf("vec%0d.retired", i), 32'(retired), 32'(vecs[i].e_ret));
         chk($sformatf("vec%0d.ir", i), ir, vecs[i].e_ir);
      end

      // Start and halt together: start wins and the halt is not remembered.
      @(negedge clk);
      start = 1'b1; halt_req = 1'b1; imem_ack = 1'b0; dec_reg_write = 1'b0;
      @(negedge clk);
      chk("restart.pc", 32'(pc), 32'd0);
      chk("restart.retired", 32'(retired), 32'd0);
      start = 1'b0; halt_req = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2000_0000;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("sw.refetch", 32'(imem_req), 32'd1);
      chk("sw.pc", 32'(pc), 32'd1);

      // Fetch timeout: still waiting after 15 FETCH cycles, aborted by 17.
      repeat (14) @(negedge clk);
      chk("to.wait_busy", 32'(busy), 32'd1);
      chk("to.wait_err", 32'(fetch_err), 32'd0);
      repeat (2) @(negedge clk);
      chk("to.err", 32'(fetch_err), 32'd1);
      chk("to.busy", 32'(busy), 32'd0);
      chk("to.req", 32'(imem_req), 32'd0);
      chk("to.pc", 32'(pc), 32'd1);
      chk("to.ir", ir, 32'h2000_0000);
      chk("to.retired", 32'(retired), 32'd1);

      // Start clears the sticky error.
      start = 1'b1;
      @(negedge clk);
      chk("clr.err", 32'(fetch_err), 32'd0);
      chk("clr.retired", 32'(retired), 32'd0);
      chk("clr.pc", 32'(pc), 32'd0);

      // Five back-to-back non-writing instructions: PC wrap and counter saturation.
      start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2000_0000; dec_reg_write = 1'b0;
      nf = 0;
      for (int c = 0; c < 30 && nf < 5; c++) begin
         if (c > 0) @(negedge clk);
         if (s_imem_req) begin
            s_addrs[nf] = s_imem_addr;
            w_addrs[nf] = imem_addr;
            nf++;
            if (nf == 5) halt_req = 1'b1;
         end
      end
      chk("wrap.fetches", 32'(nf), 32'd5);
      @(negedge clk);
      halt_req = 1'b0; imem_ack = 1'b0;
      for (int c = 0; c < 6 && busy; c++) @(negedge clk);
      chk("wrap.idle", 32'(busy), 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("wrap.saddr%0d", k), 32'(s_addrs[k]), 32'(k % 4));
         chk($sformatf("wrap.waddr%0d", k), 32'(w_addrs[k]), 32'(k));
      end
      chk("wrap.s_retired", 32'(s_retired), 32'd3);
      chk("wrap.w_retired", 32'(retired), 32'd5);
      chk("wrap.s_pc", 32'(s_pc), 32'd1);
      chk("wrap.w_pc", 32'(pc), 32'd5);

      // Reset asserted while in EXEC.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h4000_0002; dec_reg_write = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      chk("rx.in_exec", 32'(alu_en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rx.alu_en", 32'(alu_en), 32'd0);
      chk("rx.rf_we", 32'(rf_we), 32'd0);
      chk("rx.busy", 32'(busy), 32'd0);
      chk("rx.pc", 32'(pc), 32'd0);
      chk("rx.retired", 32'(retired), 32'd0);
      chk("rx.ir", ir, 32'd0);
      @(negedge clk);
      chk("rx.after", {29'd0, busy, alu_en, rf_we}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
